digit_entry_ctrl: RTL and testbench

//  Upstream feeder for the scroller's message BRAM (port A: 4 x 16-bit write, port B: 2 x 32-bit read).
//  - Debounces the raw digit/commit push-buttons.
//  - Collects up to 8 hex digits from the switches into a 32-bit message.
//  - On commit, writes the message as two 16-bit halves into the selected 32-bit slot.
//  - Drives BRAM wea/addra/dina and a live preview word for the display.

---
 rtl/eds_pkg.sv | 19 +
 rtl/btn_debounce.sv | 69 ++++++
 rtl/digit_entry_ctrl.sv | 127 ++++++++++++
 tb/tb_digit_entry_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/eds_pkg.sv
// Shared types and sizing for the digit-entry controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        WR_LO,
        WR_HI,
        DONE
    } entry_state_t;

    localparam int MSG_DIGITS = 8;   // hex digits that fit in one 32-bit slot
    localparam int HALF_W     = 16;  // BRAM port-A write width
    localparam int MSG_W      = 2 * HALF_W;
    localparam int CNT_W      = 4;   // digit counter width, holds 0..MSG_DIGITS

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stability counter, rising-edge tick.
// Latency: tick DB_CYCLES+3 cycles after a clean raw press.
// Backpressure: none; tick is a one-cycle pulse that is never held or queued.
//
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   tick     : one-cycle pulse on each accepted press
module btn_debounce
    import eds_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic tick
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_q;
    logic          armed;
    logic [1:0]    prime;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            armed    <= 1'b0;
            prime    <= 2'b00;
            cnt      <= '0;
            tick     <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            prime    <= {prime[0], 1'b1};
            stable_q <= stable;

            // Count only while the synced level disagrees with the accepted
            // level; any return to agreement restarts the window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A button already held when reset releases must be seen low
            // (once the synchronizer holds real samples) before any press
            // counts; its first accepted rise is absorbed silently.
            if (prime[1] && !sync2) begin
                armed <= 1'b1;
            end

            tick <= stable & ~stable_q & armed;
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Hex message entry: debounced buttons build a 32-bit word, commit writes it as two 16-bit halves.
// Latency: first BRAM write 1 cycle after commit tick, second write next cycle, done pulse after.
// Backpressure: none; button ticks arriving during a write sequence are dropped.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   sw           : hex digit to enter
//   btn_digit    : raw button, enter digit
//   btn_commit   : raw button, start entry / commit / cancel (commit with no digits)
//   slot_sel     : target 32-bit slot, sampled at commit
//   wea/addra/dina : BRAM port-A write; addra = {slot, half}
//   preview      : message under construction, right-justified
//   digit_count  : digits entered, 0..8
//   entry_active : high while collecting digits
//   done         : one-cycle pulse after the upper half is written
module digit_entry_ctrl
    import eds_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw,
    input  logic              btn_digit,
    input  logic              btn_commit,
    input  logic              slot_sel,
    output logic              wea,
    output logic [1:0]        addra,
    output logic [HALF_W-1:0] dina,
    output logic [MSG_W-1:0]  preview,
    output logic [CNT_W-1:0]  digit_count,
    output logic              entry_active,
    output logic              done
);

    entry_state_t state;
    logic         slot;
    logic         digit_tick;
    logic         commit_tick;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_digit (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_digit),
        .tick (digit_tick)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_commit (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_commit),
        .tick (commit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            slot         <= 1'b0;
            wea          <= 1'b0;
            addra        <= '0;
            dina         <= '0;
            preview      <= '0;
            digit_count  <= '0;
            entry_active <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Write port and done are idle unless a state below drives them.
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (commit_tick) begin
                        state        <= ENTRY;
                        preview      <= '0;
                        digit_count  <= '0;
                        entry_active <= 1'b1;
                    end
                end

                ENTRY: begin
                    // Commit takes priority over a digit tick on the same cycle.
                    if (commit_tick) begin
                        entry_active <= 1'b0;
                        if (digit_count == '0) begin
                            state <= IDLE;
                        end else begin
                            // Outputs are registered, so the low-half write is
                            // launched here to appear while the FSM sits in WR_LO.
                            slot  <= slot_sel;
                            state <= WR_LO;
                            wea   <= 1'b1;
                            addra <= {slot_sel, 1'b0};
                            dina  <= preview[HALF_W-1:0];
                        end
                    end else if (digit_tick && (digit_count < CNT_W'(MSG_DIGITS))) begin
                        preview     <= {preview[MSG_W-5:0], sw};
                        digit_count <= digit_count + 1'b1;
                    end
                end

                WR_LO: begin
                    state <= WR_HI;
                    wea   <= 1'b1;
                    addra <= {slot, 1'b1};
                    dina  <= preview[MSG_W-1:HALF_W];
                end

                WR_HI: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
module tb_digit_entry_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw;
    logic        btn_digit;
    logic        btn_commit;
    logic        slot_sel;
    logic        wea;
    logic [1:0]  addra;
    logic [15:0] dina;
    logic [31:0] preview;
    logic [3:0]  digit_count;
    logic        entry_active;
    logic        done;

    int errors = 0;
    int checks = 0;
    int wea_cycles = 0;
    int done_cycles = 0;
    int wea_mark;
    int done_mark;

    digit_entry_ctrl #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btn_digit    (btn_digit),
        .btn_commit   (btn_commit),
        .slot_sel     (slot_sel),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .preview      (preview),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Activity counters sampled mid-cycle; used to prove writes did or did not happen.
    always @(negedge clk) begin
        if (wea)  wea_cycles  = wea_cycles + 1;
        if (done) done_cycles = done_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] v);
        sw        = v;
        btn_digit = 1'b1;
        cyc(10);
        btn_digit = 1'b0;
        cyc(10);
    endtask

    task automatic press_commit();
        btn_commit = 1'b1;
        cyc(10);
        btn_commit = 1'b0;
        cyc(10);
    endtask

    // Commit that must produce a two-half write; checks exact cycle placement.
    task automatic commit_write(input logic slot, input logic [15:0] lo, input logic [15:0] hi,
                                input logic with_digit);
        slot_sel   = slot;
        btn_commit = 1'b1;
        if (with_digit) begin
            sw        = 4'hF;
            btn_digit = 1'b1;
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("wr_latency_wea0", 32'(wea), 32'd0);
        @(negedge clk);
        check("wr_lo_wea",   32'(wea),   32'd1);
        check("wr_lo_addra", 32'(addra), 32'({slot, 1'b0}));
        check("wr_lo_dina",  32'(dina),  32'(lo));
        check("wr_lo_done",  32'(done),  32'd0);
        slot_sel = ~slot;  // must not disturb the write in progress
        @(negedge clk);
        check("wr_hi_wea",   32'(wea),   32'd1);
        check("wr_hi_addra", 32'(addra), 32'({slot, 1'b1}));
        check("wr_hi_dina",  32'(dina),  32'(hi));
        @(negedge clk);
        check("post_wea",   32'(wea),   32'd0);
        check("post_addra", 32'(addra), 32'd0);
        check("post_dina",  32'(dina),  32'd0);
        check("done_pulse", 32'(done),  32'd1);
        @(negedge clk);
        check("done_clear", 32'(done),  32'd0);
        btn_commit = 1'b0;
        btn_digit  = 1'b0;
        cyc(12);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        sw         = 4'h0;
        btn_digit  = 1'b0;
        btn_commit = 1'b0;
        slot_sel   = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Reset state
        check("rst_wea",     32'(wea),          32'd0);
        check("rst_addra",   32'(addra),        32'd0);
        check("rst_dina",    32'(dina),         32'd0);
        check("rst_preview", preview,           32'd0);
        check("rst_count",   32'(digit_count),  32'd0);
        check("rst_active",  32'(entry_active), 32'd0);
        check("rst_done",    32'(done),         32'd0);

        // 1. Start entry, then bounce the digit button with sub-threshold pulses
        press_commit();
        check("t1_active", 32'(entry_active), 32'd1);
        sw = 4'h7;
        repeat (5) begin
            btn_digit = 1'b1;
            cyc(2);
            btn_digit = 1'b0;
            cyc(1);
        end
        cyc(12);
        check("t1_bounce_preview", preview,          32'd0);
        check("t1_bounce_count",   32'(digit_count), 32'd0);

        // 2. Digits 1,2,3 then commit to slot 1
        press_digit(4'h1);
        check("t2_one_digit", preview, 32'h0000_0001);
        press_digit(4'h2);
        press_digit(4'h3);
        check("t2_preview", preview,          32'h0000_0123);
        check("t2_count",   32'(digit_count), 32'd3);
        wea_mark  = wea_cycles;
        done_mark = done_cycles;
        commit_write(1'b1, 16'h0123, 16'h0000, 1'b0);
        check("t2_wea_cycles",  32'(wea_cycles - wea_mark),   32'd2);
        check("t2_done_cycles", 32'(done_cycles - done_mark), 32'd1);
        check("t2_hold_preview", preview,           32'h0000_0123);
        check("t2_hold_count",   32'(digit_count),  32'd3);
        check("t2_active",       32'(entry_active), 32'd0);

        // 3. Nine digits: count saturates at eight, ninth ignored
        press_commit();
        check("t3_start_preview", preview,          32'd0);
        check("t3_start_count",   32'(digit_count), 32'd0);
        for (int d = 1; d <= 8; d++) press_digit(4'(d));
        check("t3_preview8", preview,          32'h1234_5678);
        check("t3_count8",   32'(digit_count), 32'd8);
        press_digit(4'h9);
        check("t3_preview9", preview,          32'h1234_5678);
        check("t3_count9",   32'(digit_count), 32'd8);
        commit_write(1'b0, 16'h5678, 16'h1234, 1'b0);

        // 4. Start then commit with no digits: cancel, no write
        wea_mark  = wea_cycles;
        done_mark = done_cycles;
        press_commit();
        check("t4_active_on", 32'(entry_active), 32'd1);
        press_commit();
        check("t4_active_off",  32'(entry_active),            32'd0);
        check("t4_no_wea",      32'(wea_cycles - wea_mark),   32'd0);
        check("t4_no_done",     32'(done_cycles - done_mark), 32'd0);

        // 5. Same-cycle digit and commit with two digits entered
        press_commit();
        press_digit(4'h4);
        press_digit(4'h5);
        check("t5_preview", preview, 32'h0000_0045);
        commit_write(1'b0, 16'h0045, 16'h0000, 1'b1);
        check("t5_preview_after", preview,          32'h0000_0045);
        check("t5_count_after",   32'(digit_count), 32'd2);

        // 6. Reset during the low-half write, digit button held through reset
        press_commit();
        press_digit(4'h7);
        wea_mark   = wea_cycles;
        slot_sel   = 1'b1;
        btn_commit = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_wr_lo_wea", 32'(wea), 32'd1);
        rst       = 1'b1;
        btn_digit = 1'b1;
        @(negedge clk);
        check("t6_rst_wea",     32'(wea),          32'd0);
        check("t6_rst_addra",   32'(addra),        32'd0);
        check("t6_rst_dina",    32'(dina),         32'd0);
        check("t6_rst_preview", preview,           32'd0);
        check("t6_rst_count",   32'(digit_count),  32'd0);
        check("t6_rst_active",  32'(entry_active), 32'd0);
        check("t6_rst_done",    32'(done),         32'd0);
        check("t6_one_wea",     32'(wea_cycles - wea_mark), 32'd1);
        @(negedge clk);
        rst        = 1'b0;
        btn_commit = 1'b0;
        cyc(12);
        press_commit();
        check("t6_entry_active", 32'(entry_active), 32'd1);
        cyc(12);
        check("t6_held_no_tick", 32'(digit_count), 32'd0);
        btn_digit = 1'b0;
        cyc(12);
        press_digit(4'hA);
        check("t6_repress_count",   32'(digit_count), 32'd1);
        check("t6_repress_preview", preview,          32'h0000_000A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
